lc3_mem_arbiter: RTL and testbench
==================================

Name: lc3_mem_arbiter

Overview:
- Shares the single LC-3 memory port (mem_re/mem_we/mem_addr/mem_wdata/mem_rdata/mem_ready) between two requesters: port 0 (instruction fetch) and port 1 (data load/store).
- Accepts one request at a time and sequences it onto the memory handshake. Returns read data and a one-cycle done pulse to the winning requester.
- Sits between the LC-3 core and the memory model. The memory-side signals are the ones logged by the existing memory monitor.

Parameters:
- AW, 16, address width
- DW, 16, data width
- ARB_MODE, 1, 0 = fixed priority (port 0 wins), 1 = round-robin
- TIMEOUT_CYC, 64, watchdog limit in cycles; used only with LC3_MEM_ARB_TIMEOUT_EN

Ports:
- clk  in  1  system clock; all logic on posedge
- rst_n  in  1  synchronous active-low reset
- rq0_valid  in  1  port 0 request; held until rq0_gnt
- rq0_we  in  1  port 0: 1 = write, 0 = read
- rq0_addr  in  AW  port 0 address
- rq0_wdata  in  DW  port 0 write data
- rq0_gnt  out  1  port 0 request accepted (1-cycle pulse)
- rq0_done  out  1  port 0 access complete (1-cycle pulse)
- rq0_rdata  out  DW  port 0 read data, valid while rq0_done
- rq1_valid, rq1_we, rq1_addr, rq1_wdata, rq1_gnt, rq1_done, rq1_rdata  same as port 0
- err  out  1  timeout error, valid with done
- mem_re  out  1  memory read strobe
- mem_we  out  1  memory write strobe
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data
- mem_ready  in  1  memory completion
- txn_count  out  16  count of completed accesses

Behaviour:
- All outputs are registered.
- Reset (rst_n=0 at posedge): state=IDLE; all gnt/done/mem_re/mem_we/err=0; addr/wdata/rdata=0; txn_count=0; last_winner=1, so port 0 wins the first tie.
- FSM has two states, IDLE and ACCESS.
- IDLE:
  - If any rqX_valid is high at edge N, pick a winner.
  - Latch we/addr/wdata; state becomes ACCESS at N+1.
  - rqX_gnt is high for the single cycle N+1.
  - mem_re (read) or mem_we (write) is high from N+1.
- Arbitration:
  - ARB_MODE=0: port 0 always wins a tie.
  - ARB_MODE=1: a tie goes to the port that is not last_winner.
  - last_winner updates at grant.
- ACCESS:
  - mem_addr, mem_wdata and the strobe stay stable until mem_ready is sampled high at edge M.
  - At M+1: strobes=0; rqX_done=1 for one cycle; rqX_rdata=mem_rdata captured at M (reads only; rdata unchanged on writes); txn_count+1; state=IDLE.
- Latency: minimum 2 cycles from valid to done when mem_ready is already high in the first ACCESS cycle.
- Back-to-back: in the done cycle (IDLE) a new valid can be sampled. Its strobes appear one cycle later, so there is always at least one strobe-low cycle between accesses.
- mem_re and mem_we are never high together. Only one gnt and one done are high per cycle.
- A requester that drops valid before gnt withdraws its request; no grant is issued.
- A change in valid or addr while its own access is in ACCESS is ignored; the latched values are used.
- mem_ready high in IDLE is ignored.
- txn_count wraps from 0xFFFF to 0x0000.
- Reset mid-ACCESS: strobes drop at the reset edge; no done is issued; the pending access is lost.

Optional Feature:
- Macro: LC3_MEM_ARB_TIMEOUT_EN.
- Defined:
  - A 16-bit watchdog counts cycles in ACCESS.
  - If mem_ready is not seen within TIMEOUT_CYC cycles: strobes drop, rqX_done=1 with err=1, rqX_rdata=16'hDEAD, txn_count is not incremented, state=IDLE.
  - The watchdog clears on every grant.
- Undefined: no watchdog; ACCESS waits indefinitely; err is tied to 0.

Test Plan:
- Single read: rq0 read addr 0x3000, memory returns 0x1234 with ready after 3 cycles -> mem_re high for exactly 3 cycles, rq0_done one cycle later with rq0_rdata=0x1234, txn_count=1.
- Round-robin, ARB_MODE=1: rq0 and rq1 held valid for 4 accesses, addrs 0x3000/0x4000 -> grants alternate 0,1,0,1; mem_addr sequence 0x3000,0x4000,0x3000,0x4000; a strobe-low gap after every access.
- Fixed priority, ARB_MODE=0: both valid continuously -> port 0 wins every grant; rq1 is granted only after rq0_valid drops.
- Write then read: rq1 writes 0xBEEF to 0x4010, then reads 0x4010 -> mem_we with wdata=0xBEEF, then mem_re; rq1_rdata=0xBEEF; mem_re and mem_we never high together.
- Reset mid-access: rst_n=0 for 1 cycle while mem_re is high -> mem_re=0 and txn_count=0 at the next edge, no done pulse; a new rq0 request then completes normally.
- LC3_MEM_ARB_TIMEOUT_EN, TIMEOUT_CYC=8: mem_ready held low -> done plus err=1 and rdata=0xDEAD after 8 ACCESS cycles; txn_count unchanged.

Source files
------------

// File: rtl/lc3_mem_arbiter.sv
// Two-port arbiter sharing the LC-3 memory handshake between instruction fetch (port 0) and data (port 1).
// Optional access watchdog enabled by defining LC3_MEM_ARB_TIMEOUT_EN.
module lc3_mem_arbiter #(
  parameter int unsigned AW          = 16,
  parameter int unsigned DW          = 16,
  parameter int unsigned ARB_MODE    = 1,
  parameter int unsigned TIMEOUT_CYC = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rq0_valid,
  input  logic          rq0_we,
  input  logic [AW-1:0] rq0_addr,
  input  logic [DW-1:0] rq0_wdata,
  output logic          rq0_gnt,
  output logic          rq0_done,
  output logic [DW-1:0] rq0_rdata,
  input  logic          rq1_valid,
  input  logic          rq1_we,
  input  logic [AW-1:0] rq1_addr,
  input  logic [DW-1:0] rq1_wdata,
  output logic          rq1_gnt,
  output logic          rq1_done,
  output logic [DW-1:0] rq1_rdata,
  output logic          err,
  output logic          mem_re,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic [15:0]   txn_count
);

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  state_e        state_q, state_d;
  logic          gnt0_q, gnt0_d, gnt1_q, gnt1_d;
  logic          done0_q, done0_d, done1_q, done1_d;
  logic [DW-1:0] rdata0_q, rdata0_d, rdata1_q, rdata1_d;
  logic          err_q, err_d;
  logic          re_q, re_d, we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [15:0]   txn_q, txn_d;
  logic          last_q, last_d;
  logic          owner_q, owner_d;
  logic          pick1;
`ifdef LC3_MEM_ARB_TIMEOUT_EN
  logic [15:0]   wdog_q, wdog_d;
`endif

  // Port 1 wins only if port 0 is idle, or on a round-robin tie after port 0 last won.
  assign pick1 = rq1_valid && (!rq0_valid || ((ARB_MODE == 1) && (last_q == 1'b0)));

  always_comb begin
    state_d  = state_q;
    gnt0_d   = 1'b0;
    gnt1_d   = 1'b0;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    err_d    = 1'b0;
    rdata0_d = rdata0_q;
    rdata1_d = rdata1_q;
    re_d     = re_q;
    we_d     = we_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    txn_d    = txn_q;
    last_d   = last_q;
    owner_d  = owner_q;
`ifdef LC3_MEM_ARB_TIMEOUT_EN
    wdog_d   = wdog_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (rq0_valid || rq1_valid) begin
          state_d = StAccess;
          owner_d = pick1;
          last_d  = pick1;
          gnt0_d  = !pick1;
          gnt1_d  = pick1;
          re_d    = pick1 ? !rq1_we : !rq0_we;
          we_d    = pick1 ? rq1_we : rq0_we;
          addr_d  = pick1 ? rq1_addr : rq0_addr;
          wdata_d = pick1 ? rq1_wdata : rq0_wdata;
`ifdef LC3_MEM_ARB_TIMEOUT_EN
          wdog_d  = '0;
`endif
        end
      end
      StAccess: begin
        if (mem_ready) begin
          state_d = StIdle;
          re_d    = 1'b0;
          we_d    = 1'b0;
          done0_d = !owner_q;
          done1_d = owner_q;
          txn_d   = txn_q + 16'd1;
          if (re_q) begin
            if (owner_q) rdata1_d = mem_rdata;
            else         rdata0_d = mem_rdata;
          end
        end
`ifdef LC3_MEM_ARB_TIMEOUT_EN
        else if (wdog_q == 16'(TIMEOUT_CYC - 1)) begin
          state_d = StIdle;
          re_d    = 1'b0;
          we_d    = 1'b0;
          done0_d = !owner_q;
          done1_d = owner_q;
          err_d   = 1'b1;
          if (owner_q) rdata1_d = DW'(16'hDEAD);
          else         rdata0_d = DW'(16'hDEAD);
        end else begin
          wdog_d = wdog_q + 16'd1;
        end
`endif
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      rdata0_q <= '0;
      rdata1_q <= '0;
      err_q    <= 1'b0;
      re_q     <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      txn_q    <= '0;
      last_q   <= 1'b1;
      owner_q  <= 1'b0;
`ifdef LC3_MEM_ARB_TIMEOUT_EN
      wdog_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      rdata0_q <= rdata0_d;
      rdata1_q <= rdata1_d;
      err_q    <= err_d;
      re_q     <= re_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      txn_q    <= txn_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
`ifdef LC3_MEM_ARB_TIMEOUT_EN
      wdog_q   <= wdog_d;
`endif
    end
  end

  assign rq0_gnt   = gnt0_q;
  assign rq1_gnt   = gnt1_q;
  assign rq0_done  = done0_q;
  assign rq1_done  = done1_q;
  assign rq0_rdata = rdata0_q;
  assign rq1_rdata = rdata1_q;
  assign err       = err_q;
  assign mem_re    = re_q;
  assign mem_we    = we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign txn_count = txn_q;

endmodule

// File: tb/tb_lc3_mem_arbiter.sv
// Directed bench: one round-robin and one fixed-priority arbiter driven by identical stimulus.
module tb_lc3_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rq0_valid, rq0_we, rq1_valid, rq1_we;
  logic [15:0] rq0_addr, rq0_wdata, rq1_addr, rq1_wdata;
  logic [15:0] mem_rdata;
  logic        mem_ready;

  logic        rr_gnt0, rr_gnt1, rr_done0, rr_done1, rr_err, rr_re, rr_we;
  logic [15:0] rr_rdata0, rr_rdata1, rr_addr, rr_wdata, rr_txn;
  logic        fp_gnt0, fp_gnt1, fp_done0, fp_done1, fp_err, fp_re, fp_we;
  logic [15:0] fp_rdata0, fp_rdata1, fp_addr, fp_wdata, fp_txn;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  lc3_mem_arbiter #(.AW(16), .DW(16), .ARB_MODE(1), .TIMEOUT_CYC(8)) u_rr (
    .clk(clk), .rst_n(rst_n),
    .rq0_valid(rq0_valid), .rq0_we(rq0_we), .rq0_addr(rq0_addr), .rq0_wdata(rq0_wdata),
    .rq0_gnt(rr_gnt0), .rq0_done(rr_done0), .rq0_rdata(rr_rdata0),
    .rq1_valid(rq1_valid), .rq1_we(rq1_we), .rq1_addr(rq1_addr), .rq1_wdata(rq1_wdata),
    .rq1_gnt(rr_gnt1), .rq1_done(rr_done1), .rq1_rdata(rr_rdata1),
    .err(rr_err), .mem_re(rr_re), .mem_we(rr_we), .mem_addr(rr_addr), .mem_wdata(rr_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .txn_count(rr_txn)
  );

  lc3_mem_arbiter #(.AW(16), .DW(16), .ARB_MODE(0), .TIMEOUT_CYC(8)) u_fp (
    .clk(clk), .rst_n(rst_n),
    .rq0_valid(rq0_valid), .rq0_we(rq0_we), .rq0_addr(rq0_addr), .rq0_wdata(rq0_wdata),
    .rq0_gnt(fp_gnt0), .rq0_done(fp_done0), .rq0_rdata(fp_rdata0),
    .rq1_valid(rq1_valid), .rq1_we(rq1_we), .rq1_addr(rq1_addr), .rq1_wdata(rq1_wdata),
    .rq1_gnt(fp_gnt1), .rq1_done(fp_done1), .rq1_rdata(fp_rdata1),
    .err(fp_err), .mem_re(fp_re), .mem_we(fp_we), .mem_addr(fp_addr), .mem_wdata(fp_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready), .txn_count(fp_txn)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 ns after the edge; strobes must never overlap.
  task automatic tick();
    @(posedge clk);
    #1;
    chk("rr_excl", 32'(rr_re & rr_we), 32'd0);
    chk("fp_excl", 32'(fp_re & fp_we), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; rq0_valid = 1'b0; rq0_we = 1'b0; rq0_addr = '0; rq0_wdata = '0;
    rq1_valid = 1'b0; rq1_we = 1'b0; rq1_addr = '0; rq1_wdata = '0;
    mem_rdata = '0; mem_ready = 1'b0;
    tick(); tick();
    chk("rst_re", 32'(rr_re), 0);      chk("rst_gnt0", 32'(rr_gnt0), 0);
    chk("rst_done1", 32'(rr_done1), 0); chk("rst_addr", 32'(rr_addr), 0);
    chk("rst_rdata0", 32'(rr_rdata0), 0); chk("rst_txn", 32'(rr_txn), 0);
    chk("rst_err", 32'(rr_err), 0);
    rst_n = 1'b1;

    // Single read, ready sampled at the end of the third strobe cycle.
    rq0_valid = 1'b1; rq0_addr = 16'h3000;
    tick();
    chk("rd_gnt0", 32'(rr_gnt0), 1); chk("rd_re1", 32'(rr_re), 1);
    chk("rd_addr", 32'(rr_addr), 32'h3000); chk("rd_gnt1", 32'(rr_gnt1), 0);
    rq0_valid = 1'b0;
    tick();
    chk("rd_re2", 32'(rr_re), 1); chk("rd_gnt_pulse", 32'(rr_gnt0), 0);
    tick();
    chk("rd_re3", 32'(rr_re), 1);
    mem_ready = 1'b1; mem_rdata = 16'h1234;
    tick();
    chk("rd_re_off", 32'(rr_re), 0); chk("rd_done0", 32'(rr_done0), 1);
    chk("rd_rdata0", 32'(rr_rdata0), 32'h1234); chk("rd_txn", 32'(rr_txn), 1);
    chk("rd_err", 32'(rr_err), 0);
    tick();
    chk("rd_done_pulse", 32'(rr_done0), 0);

    // Ready while idle must not produce anything.
    tick();
    chk("idle_done0", 32'(rr_done0), 0); chk("idle_txn", 32'(rr_txn), 1);
    mem_ready = 1'b0;

    // Port 1 write then read back.
    rq1_valid = 1'b1; rq1_we = 1'b1; rq1_addr = 16'h4010; rq1_wdata = 16'hBEEF;
    tick();
    chk("wr_gnt1", 32'(rr_gnt1), 1); chk("wr_we", 32'(rr_we), 1); chk("wr_re", 32'(rr_re), 0);
    chk("wr_addr", 32'(rr_addr), 32'h4010); chk("wr_wdata", 32'(rr_wdata), 32'hBEEF);
    rq1_valid = 1'b0; mem_ready = 1'b1; mem_rdata = 16'h0BAD;
    tick();
    chk("wr_done1", 32'(rr_done1), 1); chk("wr_we_off", 32'(rr_we), 0);
    chk("wr_rdata_hold", 32'(rr_rdata1), 0); chk("wr_txn", 32'(rr_txn), 2);
    mem_ready = 1'b0;
    rq1_valid = 1'b1; rq1_we = 1'b0;
    tick();
    chk("rb_gnt1", 32'(rr_gnt1), 1); chk("rb_re", 32'(rr_re), 1); chk("rb_we", 32'(rr_we), 0);
    rq1_valid = 1'b0; mem_ready = 1'b1; mem_rdata = 16'hBEEF;
    tick();
    chk("rb_done1", 32'(rr_done1), 1); chk("rb_rdata1", 32'(rr_rdata1), 32'hBEEF);
    chk("rb_txn", 32'(rr_txn), 3);

    // Both ports held valid: round-robin alternates, fixed priority keeps port 0.
    rq0_valid = 1'b1; rq0_we = 1'b0; rq0_addr = 16'h3000;
    rq1_valid = 1'b1; rq1_we = 1'b0; rq1_addr = 16'h4000;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rr_gnt0", 32'(rr_gnt0), 32'(i % 2 == 0));
      chk("rr_gnt1", 32'(rr_gnt1), 32'(i % 2 == 1));
      chk("rr_addr", 32'(rr_addr), (i % 2 == 1) ? 32'h4000 : 32'h3000);
      chk("rr_re", 32'(rr_re), 1);
      chk("fp_gnt0", 32'(fp_gnt0), 1); chk("fp_gnt1", 32'(fp_gnt1), 0);
      chk("fp_addr", 32'(fp_addr), 32'h3000);
      tick();
      chk("rr_gap", 32'(rr_re), 0);
      chk("rr_done0", 32'(rr_done0), 32'(i % 2 == 0));
      chk("rr_done1", 32'(rr_done1), 32'(i % 2 == 1));
      chk("fp_done0", 32'(fp_done0), 1); chk("fp_gap", 32'(fp_re), 0);
    end
    rq0_valid = 1'b0;
    tick();
    chk("fp_gnt1_late", 32'(fp_gnt1), 1); chk("fp_addr_late", 32'(fp_addr), 32'h4000);
    chk("rr_gnt1_late", 32'(rr_gnt1), 1);
    rq1_valid = 1'b0;
    tick();
    chk("fp_done1_late", 32'(fp_done1), 1);
    chk("rr_txn8", 32'(rr_txn), 8); chk("fp_txn8", 32'(fp_txn), 8);
    mem_ready = 1'b0;
    tick();

`ifdef LC3_MEM_ARB_TIMEOUT_EN
    rq0_valid = 1'b1; rq0_addr = 16'h3000;
    tick();
    chk("to_gnt0", 32'(rr_gnt0), 1);
    rq0_valid = 1'b0;
    repeat (7) tick();
    chk("to_re_held", 32'(rr_re), 1); chk("to_no_done", 32'(rr_done0), 0);
    tick();
    chk("to_done0", 32'(rr_done0), 1); chk("to_err", 32'(rr_err), 1);
    chk("to_rdata0", 32'(rr_rdata0), 32'hDEAD); chk("to_txn", 32'(rr_txn), 8);
    chk("to_re_off", 32'(rr_re), 0);
    tick();
    chk("to_err_pulse", 32'(rr_err), 0);
`endif

    // Reset in the middle of an access drops it silently.
    rq0_valid = 1'b1; rq0_addr = 16'h5000;
    tick();
    chk("mr_re", 32'(rr_re), 1);
    rst_n = 1'b0; rq0_valid = 1'b0;
    tick();
    chk("mr_re_off", 32'(rr_re), 0); chk("mr_txn", 32'(rr_txn), 0);
    chk("mr_done", 32'(rr_done0), 0);
    rst_n = 1'b1;
    tick();
    chk("mr_done_after", 32'(rr_done0), 0); chk("mr_gnt_after", 32'(rr_gnt0), 0);
    rq0_valid = 1'b1; rq0_addr = 16'h3000; mem_ready = 1'b1; mem_rdata = 16'h5A5A;
    tick();
    chk("mr_new_gnt", 32'(rr_gnt0), 1); chk("mr_new_addr", 32'(rr_addr), 32'h3000);
    rq0_valid = 1'b0;
    tick();
    chk("mr_new_done", 32'(rr_done0), 1); chk("mr_new_rdata", 32'(rr_rdata0), 32'h5A5A);
    chk("mr_new_txn", 32'(rr_txn), 1);
    mem_ready = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
